// File: rtl/axicb_scfifo_ctrl_if.sv
// Push/pop valid-ready handshake between the FIFO control stage and the crossbar.
// The FIFO side is the slave; the crossbar side (producer and consumer) is the master.
interface axicb_scfifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/axicb_scfifo_ctrl.sv
// Single-clock FIFO control: pointers, level and flags around an external dual-port RAM; 1-cycle push-to-out_valid.
// Backpressure: in_ready drops on the registered full flag (no pass-through); out_data holds while out_ready is low.
module axicb_scfifo_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int FFD_EN        = 0,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  srst,
  axicb_scfifo_ctrl_if.slave    bus,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] MSB_ONLY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic                push, pop;

  // A push in the srst cycle is discarded, so it must not advance anything.
  assign push          = bus.in_valid & ~full & ~srst;
  assign pop           = ~empty & bus.out_ready;
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;

  assign ram_wr_en   = push;
  assign ram_addr_in = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_data_in = bus.in_data;

  assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + PTR_ONE;
    else if (pop && !push) level_nxt = level - PTR_ONE;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      full   <= ((wr_ptr_nxt ^ rd_ptr_nxt) == MSB_ONLY);
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      afull  <= (level_nxt >= AFULL_L);
      aempty <= (level_nxt <= AEMPTY_L);
    end
  end

  if (FFD_EN != 0) begin : g_ffd
    logic                  byp_vld;
    logic [DATA_WIDTH-1:0] byp_dat;

    // Prefetch the entry the head will point at after this cycle's pop.
    assign ram_addr_out = rd_ptr_nxt[ADDR_WIDTH-1:0];

    // Writing the address being prefetched returns stale RAM data; forward it instead.
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        byp_vld <= 1'b0;
        byp_dat <= '0;
      end else if (srst) begin
        byp_vld <= 1'b0;
      end else begin
        byp_vld <= push && (ram_addr_in == ram_addr_out);
        if (push && (ram_addr_in == ram_addr_out)) byp_dat <= bus.in_data;
      end
    end

    assign bus.out_data = byp_vld ? byp_dat : ram_data_out;
  end else begin : g_comb
    assign ram_addr_out = rd_ptr[ADDR_WIDTH-1:0];
    assign bus.out_data = ram_data_out;
  end

  a_no_x_out: assert property (@(posedge aclk) disable iff (arst)
    bus.out_valid |-> !$isunknown(bus.out_data));
  a_level_max: assert property (@(posedge aclk) disable iff (arst) level <= DEPTH_L);
  a_full_empty: assert property (@(posedge aclk) disable iff (arst) !(full && empty));
endmodule

// File: tb/tb_axicb_scfifo_ctrl.sv
// Two controllers (combinational and registered RAM read) driven in lockstep, checked against a queue model.
// Literal checks pin reset values, ordering, full handling, wrap, bypass, arst and srst.
module tb_axicb_scfifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  logic srst = 1'b0;
  logic iv = 1'b0;
  logic ordy = 1'b0;
  logic [DW-1:0] idat = '0;

  always #5 aclk = ~aclk;

  axicb_scfifo_ctrl_if #(.DATA_WIDTH(DW)) bus0 ();
  axicb_scfifo_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.in_valid  = iv;
  assign bus0.in_data   = idat;
  assign bus0.out_ready = ordy;
  assign bus1.in_valid  = iv;
  assign bus1.in_data   = idat;
  assign bus1.out_ready = ordy;

  logic [AW:0]   lvl0, lvl1;
  logic          fu0, fu1, em0, em1, af0, af1, ae0, ae1;
  logic          wen0, wen1;
  logic [AW-1:0] wa0, wa1, ra0, ra1;
  logic [DW-1:0] wd0, wd1, rd0, rd1;

  axicb_scfifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FFD_EN(0),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u0 (
    .aclk(aclk), .arst(arst), .srst(srst), .bus(bus0),
    .level(lvl0), .full(fu0), .empty(em0), .afull(af0), .aempty(ae0),
    .ram_wr_en(wen0), .ram_addr_in(wa0), .ram_data_in(wd0),
    .ram_addr_out(ra0), .ram_data_out(rd0)
  );

  axicb_scfifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FFD_EN(1),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u1 (
    .aclk(aclk), .arst(arst), .srst(srst), .bus(bus1),
    .level(lvl1), .full(fu1), .empty(em1), .afull(af1), .aempty(ae1),
    .ram_wr_en(wen1), .ram_addr_in(wa1), .ram_data_in(wd1),
    .ram_addr_out(ra1), .ram_data_out(rd1)
  );

  // RAM models: asynchronous read for u0, registered read-before-write for u1.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge aclk) if (wen0) mem0[wa0] <= wd0;
  assign rd0 = mem0[ra0];
  always @(posedge aclk) begin
    if (wen1) mem1[wa1] <= wd1;
    rd1 <= mem1[ra1];
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [DW-1:0] q [$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic cmp(input int d, input logic ir, input logic ov, input logic [DW-1:0] od,
                     input logic [AW:0] lv, input logic fu, input logic em,
                     input logic af, input logic ae);
    int n = q.size();
    chk($sformatf("d%0d_level", d), lv, n);
    chk($sformatf("d%0d_in_ready", d), ir, (n < DEPTH) ? 1 : 0);
    chk($sformatf("d%0d_out_valid", d), ov, (n > 0) ? 1 : 0);
    chk($sformatf("d%0d_full", d), fu, (n == DEPTH) ? 1 : 0);
    chk($sformatf("d%0d_empty", d), em, (n == 0) ? 1 : 0);
    chk($sformatf("d%0d_afull", d), af, (n >= AF) ? 1 : 0);
    chk($sformatf("d%0d_aempty", d), ae, (n <= AE) ? 1 : 0);
    if (n > 0) chk($sformatf("d%0d_out_data", d), od, q[0]);
  endtask

  // Reference model: a queue of accepted words, updated at each edge, compared 1 ns later.
  initial begin
    bit mpush, mpop;
    forever begin
      @(posedge aclk);
      if (arst || srst) begin
        q.delete();
      end else begin
        mpush = iv && (q.size() < DEPTH);
        mpop  = ordy && (q.size() > 0);
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(idat);
      end
      #1;
      cmp(0, bus0.in_ready, bus0.out_valid, bus0.out_data, lvl0, fu0, em0, af0, ae0);
      cmp(1, bus1.in_ready, bus1.out_valid, bus1.out_data, lvl1, fu1, em1, af1, ae1);
    end
  end

  // Apply inputs at the current falling edge and return at the next one.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    iv = v;
    idat = d;
    ordy = r;
    @(negedge aclk);
  endtask

  task automatic lit_state(input string nm, input int unsigned lv, input logic em,
                           input logic ir, input logic ov);
    chk({nm, "_lvl0"}, lvl0, lv);
    chk({nm, "_lvl1"}, lvl1, lv);
    chk({nm, "_empty0"}, em0, em);
    chk({nm, "_empty1"}, em1, em);
    chk({nm, "_in_ready0"}, bus0.in_ready, ir);
    chk({nm, "_in_ready1"}, bus1.in_ready, ir);
    chk({nm, "_out_valid0"}, bus0.out_valid, ov);
    chk({nm, "_out_valid1"}, bus1.out_valid, ov);
  endtask

  task automatic lit_data(input string nm, input logic [DW-1:0] want);
    chk({nm, "_data0"}, bus0.out_data, want);
    chk({nm, "_data1"}, bus1.out_data, want);
  endtask

  initial begin
    logic [DW-1:0] e3 [3] = '{8'h11, 8'h22, 8'h33};

    repeat (3) @(negedge aclk);
    lit_state("reset", 0, 1'b1, 1'b1, 1'b0);
    arst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    lit_state("idle", 0, 1'b1, 1'b1, 1'b0);

    // Three pushes with the consumer stalled, then drain in order.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    lit_state("three", 3, 1'b0, 1'b1, 1'b1);
    lit_data("held", 8'h11);
    for (int k = 0; k < 3; k++) begin
      lit_data($sformatf("drain3_%0d", k), e3[k]);
      cyc(1'b0, 8'h00, 1'b1);
    end
    lit_state("drained", 0, 1'b1, 1'b1, 1'b0);

    // Fill to DEPTH, try an extra push, then alternate pop/push across the wrap.
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 8'(8'hA0 + k), 1'b0);
    chk("full_flag0", fu0, 1);
    chk("full_flag1", fu1, 1);
    lit_state("full", DEPTH, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0);
    lit_state("fifth_push", DEPTH, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b1, 8'(8'hB0 + i), 1'b0);
    end
    lit_state("wrapped", DEPTH, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      lit_data($sformatf("wrap_%0d", k), 8'(8'hB6 + k));
      cyc(1'b0, 8'h00, 1'b1);
    end
    lit_state("wrap_empty", 0, 1'b1, 1'b1, 1'b0);

    // Level 1 with push and pop every cycle: each new word collides with the prefetch.
    cyc(1'b1, 8'h40, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      lit_data($sformatf("byp_%0d", k), 8'(8'h40 + k - 1));
      cyc(1'b1, 8'(8'h40 + k), 1'b1);
    end
    lit_state("byp_level", 1, 1'b0, 1'b1, 1'b1);
    lit_data("byp_last", 8'h4C);
    cyc(1'b0, 8'h00, 1'b1);
    lit_state("byp_empty", 0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    iv = 1'b0;
    #2 arst = 1'b1;
    #1 lit_state("arst_async", 0, 1'b1, 1'b1, 1'b0);
    @(negedge aclk);
    arst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    lit_state("arst_after", 0, 1'b1, 1'b1, 1'b0);

    // Synchronous clear with a concurrent push.
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    lit_state("pre_srst", 3, 1'b0, 1'b1, 1'b1);
    srst = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    srst = 1'b0;
    lit_state("srst", 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    lit_state("post_srst", 0, 1'b1, 1'b1, 1'b0);

    // Random traffic, 50% valid and 50% ready.
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    cyc(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axicb_scfifo_ctrl.md
Name: axicb_scfifo_ctrl

Overview:
- Control stage of the single-clock FIFO. It sits directly upstream of the dual-port FIFO RAM, which it drives, and it presents valid/ready push and pop interfaces to the crossbar.
- Owns the read/write pointers, the fill level and the full/empty/threshold flags.
- Hides the RAM read latency when the RAM is built with a registered output (FFD_EN=1).

Parameters:
- ADDR_WIDTH, 8: RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: payload width.
- FFD_EN, 0: must match the RAM's setting; 1 means RAM read data arrives one cycle after the address.
- AFULL_THRESH, 2**ADDR_WIDTH-2: afull asserts when level >= this value.
- AEMPTY_THRESH, 2: aempty asserts when level <= this value.

Ports:
- aclk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active high.
- srst  in  1  synchronous clear, active high.
- in_valid  in  1  push request.
- in_ready  out  1  push accept.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  pop data available.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH  pop payload.
- level  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- afull  out  1  almost-full flag.
- aempty  out  1  almost-empty flag.
- ram_wr_en  out  1  RAM write enable.
- ram_addr_in  out  ADDR_WIDTH  RAM write address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_addr_out  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Clock and reset: one clock, aclk. arst is asynchronous and active high. srst is synchronous.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The RAM address is the low ADDR_WIDTH bits. The MSB is the wrap bit.
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Reset (arst asynchronous, or srst at the clock edge):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, full=0, afull=0, aempty=1.
  - in_ready=1, out_valid=0, ram_wr_en=0.
  - Bypass valid cleared.
  - out_data is don't-care while out_valid=0.
  - RAM contents are not cleared.
- Push:
  - in_ready = !full, registered-flag based. There is no pass-through when full, even if a pop occurs in the same cycle.
  - push = in_valid & in_ready.
  - ram_wr_en = push, ram_addr_in = wr_ptr[ADDR_WIDTH-1:0], ram_data_in = in_data, all combinational.
  - wr_ptr increments on push.
- Pop:
  - pop = out_valid & out_ready.
  - rd_ptr increments on pop.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Level:
  - push only: +1. pop only: -1. Both or neither: unchanged.
  - Flags are registered and derived from the next level, so they are valid in the cycle after the event.
- FFD_EN=0:
  - ram_addr_out = rd_ptr[ADDR_WIDTH-1:0].
  - out_data = ram_data_out.
  - out_valid = !empty.
  - First push into an empty FIFO: out_valid rises the next cycle (1-cycle latency).
- FFD_EN=1:
  - ram_addr_out = rd_ptr_next[ADDR_WIDTH-1:0], where rd_ptr_next = rd_ptr + pop. The RAM register therefore presents the entry at rd_ptr in the following cycle.
  - Collision: if push and ram_addr_in == ram_addr_out in the same cycle, the RAM returns stale data. In that case the controller captures in_data into a bypass register and sets byp_vld.
  - Next cycle, out_data = bypass register if byp_vld, else ram_data_out. byp_vld clears every cycle unless it is set again.
  - out_valid = !empty. Latency from the first push into empty to out_valid is 1 cycle, same as FFD_EN=0.
- Simultaneous push and pop:
  - When empty, pop cannot occur (out_valid=0); level goes to 1.
  - When full, push cannot occur; level goes to DEPTH-1.
  - Otherwise both proceed and level is unchanged.
- Protocol assertions:
  - No X on out_data while out_valid=1.
  - level never exceeds DEPTH.
  - full and empty are never both 1.

Test Plan:
- Reset then idle, both FFD_EN values → empty=1, in_ready=1, out_valid=0, level=0; arst asserted mid-stream forces the same values immediately, without waiting for a clock edge.
- Push 0x11,0x22,0x33 with out_ready=0 → level=3, out_valid=1, out_data=0x11 held; then out_ready=1 → 0x11,0x22,0x33 on consecutive cycles, then empty=1.
- ADDR_WIDTH=2: push 4 words → full=1, in_ready=0; a 5th push with in_valid=1 is ignored; pop 1 and push 1 repeated 10 times → pointers wrap and all data emerges in order.
- FFD_EN=1, single push into empty, then push and pop every cycle with level=1 → collision bypass exercised every cycle, out_data matches the push sequence exactly, no stale value.
- Random valid/ready at 50%/50% for 10k cycles on both FFD_EN values → scoreboard in-order match; afull/aempty track level against thresholds; level equals pushes minus pops.
- srst asserted with level=3 while in_valid=1 → next cycle level=0, empty=1, and the push in the srst cycle is discarded.
